// File: rtl/hazard_sched_pkg.sv
// Shared types for the RV32I pipeline scheduler: FSM states, forwarding selects
// and the per-stage shadow tag kept alongside the datapath registers.
package hazard_sched_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wren;
    logic       is_load;
    logic       is_mem;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  // x0 is hardwired, so a producer targeting rd=0 never supplies a value.
  function automatic logic tag_writes(input stage_tag_t tag, input logic [4:0] rs);
    return tag.valid & tag.wren & (tag.rd != 5'd0) & (tag.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_sched_fwd_select.sv
// Operand forwarding select for one EX source register; the younger MEM
// producer takes precedence over the older WB producer.
module fwd_select
  import hazard_sched_pkg::*;
(
  input  logic [4:0] i_rs,
  input  stage_tag_t i_mem_tag,
  input  stage_tag_t i_wb_tag,
  output fwd_sel_e   o_sel
);

  logic w_unused;
  assign w_unused = ^{i_mem_tag.is_load, i_mem_tag.is_mem, i_mem_tag.rs1, i_mem_tag.rs2,
                      i_wb_tag.is_load, i_wb_tag.is_mem, i_wb_tag.rs1, i_wb_tag.rs2};

  always_comb begin
    o_sel = FWD_RF;
    if (tag_writes(i_mem_tag, i_rs)) begin
      o_sel = FWD_MEM;
    end else if (tag_writes(i_wb_tag, i_rs)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline scheduler for the 5-stage RV32I core: per-cycle advance/hold/bubble
// control and EX forwarding, driven by shadow tags of the EX/MEM/WB stages.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic [4:0] id_rd_addr_i,
  input  logic       id_rd_wren_i,
  input  logic       id_is_load_i,
  input  logic       id_is_store_i,
  input  logic       ex_redirect_i,
  input  logic       dmem_ready_i,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       id_ex_en_o,
  output logic       ex_mem_en_o,
  output logic       mem_wb_en_o,
  output logic       if_id_flush_o,
  output logic       id_ex_flush_o,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o,
  output logic       mem_timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

  hz_state_e        r_state, w_state_nxt;
  stage_tag_t       r_ex, r_mem, r_wb;
  stage_tag_t       w_id_tag, w_ex_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_freeze, w_lu_hit;
  fwd_sel_e         w_fwd_a, w_fwd_b;

  always_comb begin
    w_id_tag = TAG_BUBBLE;
    if (id_valid_i) begin
      w_id_tag.valid   = 1'b1;
      w_id_tag.rd      = id_rd_addr_i;
      w_id_tag.wren    = id_rd_wren_i;
      w_id_tag.is_load = id_is_load_i;
      w_id_tag.is_mem  = id_is_load_i | id_is_store_i;
      w_id_tag.rs1     = id_rs1_addr_i;
      w_id_tag.rs2     = id_rs2_addr_i;
    end
  end

  assign w_freeze = r_mem.valid & r_mem.is_mem & ~dmem_ready_i;
  assign w_lu_hit = id_valid_i & r_ex.valid & r_ex.is_load & (r_ex.rd != 5'd0) &
                    ((r_ex.rd == id_rs1_addr_i) | (r_ex.rd == id_rs2_addr_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority: MEM freeze, then redirect, then load-use. Redirect is qualified
  // with rst_ni so the control outputs sit at their idle values throughout reset.
  always_comb begin
    w_state_nxt   = RUN;
    w_ex_nxt      = w_id_tag;
    pc_en_o       = 1'b1;
    if_id_en_o    = 1'b1;
    id_ex_en_o    = 1'b1;
    ex_mem_en_o   = 1'b1;
    mem_wb_en_o   = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    if (w_freeze) begin
      w_state_nxt = MEM_WAIT;
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (ex_redirect_i && rst_ni) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      w_ex_nxt      = TAG_BUBBLE;
    end else if (w_lu_hit && (r_state != LU_STALL)) begin
      w_state_nxt   = LU_STALL;
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
      w_ex_nxt      = TAG_BUBBLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ex  <= TAG_BUBBLE;
      r_mem <= TAG_BUBBLE;
      r_wb  <= TAG_BUBBLE;
    end else if (!w_freeze) begin
      r_ex  <= w_ex_nxt;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // Counter saturates at MEM_WAIT_MAX; the timeout flag sets on the edge the
  // counter reaches it and stays set until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (w_freeze) begin
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt >= (CNT_MAX - 1'b1)) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  fwd_select u_fwd_a (
    .i_rs      (r_ex.rs1),
    .i_mem_tag (r_mem),
    .i_wb_tag  (r_wb),
    .o_sel     (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_rs      (r_ex.rs2),
    .i_mem_tag (r_mem),
    .i_wb_tag  (r_wb),
    .o_sel     (w_fwd_b)
  );

  assign fwd_a_sel_o   = w_fwd_a;
  assign fwd_b_sel_o   = w_fwd_b;
  assign mem_timeout_o = r_timeout;

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: stimulus pushes hand-computed expected
// control vectors, a negedge monitor pops and compares them every cycle.
module tb_hazard_sched;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs1_addr_i = '0;
  logic [4:0] id_rs2_addr_i = '0;
  logic [4:0] id_rd_addr_i = '0;
  logic       id_rd_wren_i = 1'b0;
  logic       id_is_load_i = 1'b0;
  logic       id_is_store_i = 1'b0;
  logic       ex_redirect_i = 1'b0;
  logic       dmem_ready_i = 1'b1;
  logic       pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic       if_id_flush_o, id_ex_flush_o, mem_timeout_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;

  hazard_sched #(.MEM_WAIT_MAX(2), .CNT_W(2)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .id_valid_i    (id_valid_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rd_addr_i  (id_rd_addr_i),
    .id_rd_wren_i  (id_rd_wren_i),
    .id_is_load_i  (id_is_load_i),
    .id_is_store_i (id_is_store_i),
    .ex_redirect_i (ex_redirect_i),
    .dmem_ready_i  (dmem_ready_i),
    .pc_en_o       (pc_en_o),
    .if_id_en_o    (if_id_en_o),
    .id_ex_en_o    (id_ex_en_o),
    .ex_mem_en_o   (ex_mem_en_o),
    .mem_wb_en_o   (mem_wb_en_o),
    .if_id_flush_o (if_id_flush_o),
    .id_ex_flush_o (id_ex_flush_o),
    .fwd_a_sel_o   (fwd_a_sel_o),
    .fwd_b_sel_o   (fwd_b_sel_o),
    .mem_timeout_o (mem_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  localparam logic [6:0] RUNV = 7'b1111100;
  localparam logic [6:0] LUV  = 7'b0011101;
  localparam logic [6:0] RDRV = 7'b1111111;
  localparam logic [6:0] FRZV = 7'b0000000;

  typedef struct {
    logic        chk;
    string       nm;
    logic [11:0] vec;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned n_eval = 0;
  int unsigned n_fail = 0;
  logic [11:0] w_act;

  assign w_act = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
                  if_id_flush_o, id_ex_flush_o, fwd_a_sel_o, fwd_b_sel_o, mem_timeout_o};

  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk) begin
        n_eval++;
        if (w_act !== mon_e.vec) begin
          n_fail++;
          $display("FAIL %s: got ctl/fa/fb/to=%b required %b", mon_e.nm, w_act, mon_e.vec);
        end
      end
    end
  end

  task automatic step(input string nm, input logic chk, input logic rstn,
                      input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic wr, input logic ld,
                      input logic st, input logic rdr, input logic rdy,
                      input logic [6:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic to);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni        = rstn;
    id_valid_i    = v;
    id_rd_addr_i  = rd;
    id_rs1_addr_i = rs1;
    id_rs2_addr_i = rs2;
    id_rd_wren_i  = wr;
    id_is_load_i  = ld;
    id_is_store_i = st;
    ex_redirect_i = rdr;
    dmem_ready_i  = rdy;
    e.chk = chk;
    e.nm  = nm;
    e.vec = {ctl, fa, fb, to};
    exp_q.push_back(e);
  endtask

  task automatic nop(input string nm, input logic rdr, input logic rdy,
                     input logic [6:0] ctl, input logic [1:0] fa,
                     input logic [1:0] fb, input logic to);
    step(nm, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, rdr, rdy, ctl, fa, fb, to);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      step("drain", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
           RUNV, 2'b00, 2'b00, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with redirect asserted: control must still be idle.
    step("reset", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, RUNV, 2'b00, 2'b00, 0);

    // addi x5 ; add x6,x5,x1 ; add x7,x1,x5
    step("t1_addi",    1, 1, 1, 5'd5, 5'd1, 5'd0, 1, 0, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    step("t1_add_id",  1, 1, 1, 5'd6, 5'd5, 5'd1, 1, 0, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    step("t1_fwd_mem", 1, 1, 1, 5'd7, 5'd1, 5'd5, 1, 0, 0, 0, 1, RUNV, 2'b01, 2'b00, 0);
    nop("t1_fwd_wb", 0, 1, RUNV, 2'b00, 2'b10, 0);
    drain();

    // two writers of x8 in MEM and WB: MEM wins
    step("pr_a", 1, 1, 1, 5'd8, 5'd0, 5'd0, 1, 0, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    step("pr_b", 1, 1, 1, 5'd8, 5'd0, 5'd0, 1, 0, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    step("pr_c", 1, 1, 1, 5'd9, 5'd8, 5'd8, 1, 0, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    nop("pr_mem_wins", 0, 1, RUNV, 2'b01, 2'b01, 0);
    drain();

    // lw x5 ; add x7,x5,x5 -> single stall then WB forward
    step("lu_load",  1, 1, 1, 5'd5, 5'd2, 5'd0, 1, 1, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    step("lu_stall", 1, 1, 1, 5'd7, 5'd5, 5'd5, 1, 0, 0, 0, 1, LUV,  2'b00, 2'b00, 0);
    step("lu_once",  1, 1, 1, 5'd7, 5'd5, 5'd5, 1, 0, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    nop("lu_fwd_wb", 0, 1, RUNV, 2'b10, 2'b10, 0);
    drain();

    // lw x0 never stalls or forwards
    step("x0_load", 1, 1, 1, 5'd0, 5'd3, 5'd0, 1, 1, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    step("x0_user", 1, 1, 1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    nop("x0_nofwd", 0, 1, RUNV, 2'b00, 2'b00, 0);
    drain();

    // redirect coinciding with load-use
    step("rd_load",    1, 1, 1, 5'd5, 5'd2, 5'd0, 1, 1, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    step("rd_vs_lu",   1, 1, 1, 5'd7, 5'd5, 5'd5, 1, 0, 0, 1, 1, RDRV, 2'b00, 2'b00, 0);
    step("rd_nostall", 1, 1, 1, 5'd7, 5'd5, 5'd5, 1, 0, 0, 0, 1, RUNV, 2'b00, 2'b00, 0);
    nop("rd_fwd_wb", 0, 1, RUNV, 2'b10, 2'b10, 0);
    drain();

    // sw waits 3 cycles in MEM; MEM_WAIT_MAX=2 trips the sticky timeout
    step("sw_id", 1, 1, 1, 5'd0, 5'd2, 5'd5, 0, 0, 1, 0, 1, RUNV, 2'b00, 2'b00, 0);
    nop("sw_ex",     0, 1, RUNV, 2'b00, 2'b00, 0);
    nop("frz1",      0, 0, FRZV, 2'b00, 2'b00, 0);
    nop("frz2_rdr",  1, 0, FRZV, 2'b00, 2'b00, 0);
    nop("frz3_to",   1, 0, FRZV, 2'b00, 2'b00, 1);
    nop("release",   0, 1, RUNV, 2'b00, 2'b00, 1);
    nop("to_sticky", 0, 1, RUNV, 2'b00, 2'b00, 1);

    // reset asserted mid-freeze clears everything without a clock edge
    step("sw2_id", 1, 1, 1, 5'd0, 5'd2, 5'd5, 0, 0, 1, 0, 1, RUNV, 2'b00, 2'b00, 1);
    nop("sw2_ex", 0, 1, RUNV, 2'b00, 2'b00, 1);
    nop("frz_b",  0, 0, FRZV, 2'b00, 2'b00, 1);
    step("async_rst", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, RUNV, 2'b00, 2'b00, 0);
    nop("post_rst", 0, 0, RUNV, 2'b00, 2'b00, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk_i);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
